// File: rtl/reg_bank_controller_pkg.sv
// Shared constants and state encoding for the alarm-clock register bank controller.
package reg_bank_controller_pkg;

    localparam int unsigned DATA_W       = 13;
    localparam int unsigned SEL_W        = 3;
    localparam int unsigned NUM_REGS     = 7;
    localparam int unsigned NUM_REQ      = 3;
    localparam int unsigned ADDR_TIME    = 0;
    localparam int unsigned ADDR_INVALID = 7;
    localparam int unsigned ARMED_BIT    = DATA_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_SCAN  = 2'd2
    } state_t;

endpackage

// File: rtl/reg_bank_controller_rr_arbiter.sv
// Three-way round-robin arbiter. ptr names the requester that gets first look;
// after a grant it moves to the requester following the winner.
module rr_arbiter3
    import reg_bank_controller_pkg::*;
(
    input  logic               Clock,
    input  logic               Clear,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    output logic [NUM_REQ-1:0] winner
);

    logic [1:0] ptr;

    // Priority search starting at ptr, wrapping around.
    always_comb begin
        winner = '0;
        case (ptr)
            2'd0: begin
                if      (req[0]) winner = 3'b001;
                else if (req[1]) winner = 3'b010;
                else if (req[2]) winner = 3'b100;
            end
            2'd1: begin
                if      (req[1]) winner = 3'b010;
                else if (req[2]) winner = 3'b100;
                else if (req[0]) winner = 3'b001;
            end
            default: begin
                if      (req[2]) winner = 3'b100;
                else if (req[0]) winner = 3'b001;
                else if (req[1]) winner = 3'b010;
            end
        endcase
    end

    // Advance the first-look pointer past the requester just granted.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            ptr <= 2'd0;
        end else if (update) begin
            if (winner[0])      ptr <= 2'd1;
            else if (winner[1]) ptr <= 2'd2;
            else if (winner[2]) ptr <= 2'd0;
        end
    end

endmodule

// File: rtl/reg_bank_controller.sv
// Write-port sequencer/arbiter for the 7-register alarm-clock bank.
// Build option ALARM_SCAN_EN: when defined, every write to register 0 is
// followed by a 6-cycle scan of alarm registers 1-6; otherwise no scan exists.
module reg_bank_controller
    import reg_bank_controller_pkg::*;
#(
    parameter int unsigned DATA_W = reg_bank_controller_pkg::DATA_W,
    parameter int unsigned SEL_W  = reg_bank_controller_pkg::SEL_W
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic [2:0]        req,
    input  logic [SEL_W-1:0]  req_addr0,
    input  logic [SEL_W-1:0]  req_addr1,
    input  logic [SEL_W-1:0]  req_addr2,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    input  logic [DATA_W-1:0] req_data2,
    output logic [2:0]        gnt,
    output logic [SEL_W-1:0]  STO,
    output logic [DATA_W-1:0] D,
    output logic              Enable,
    output logic              bad_addr,
    output logic [SEL_W-1:0]  scan_sel,
    input  logic [DATA_W-1:0] scan_q,
    output logic [5:0]        match_mask,
    output logic              alarm_hit,
    input  logic              alarm_ack
);

    localparam logic [SEL_W-1:0] SEL_TIME    = SEL_W'(ADDR_TIME);
    localparam logic [SEL_W-1:0] SEL_INVALID = SEL_W'(ADDR_INVALID);
    localparam logic [SEL_W-1:0] SEL_FIRST   = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(NUM_REGS - 1);

    state_t            state, state_next;
    logic              start;
    logic [2:0]        winner;
    logic [SEL_W-1:0]  win_addr;
    logic [DATA_W-1:0] win_data;

    assign start = (state == ST_IDLE) && (req != '0);

    rr_arbiter3 u_arb (
        .Clock  (Clock),
        .Clear  (Clear),
        .req    (req),
        .update (start),
        .winner (winner)
    );

    // Route the winning requester's address and data toward the write port.
    always_comb begin
        win_addr = '0;
        win_data = '0;
        if (winner[0]) begin
            win_addr = req_addr0;
            win_data = req_data0;
        end else if (winner[1]) begin
            win_addr = req_addr1;
            win_data = req_data1;
        end else if (winner[2]) begin
            win_addr = req_addr2;
            win_data = req_data2;
        end
    end

    // Registered write port: active only during the WRITE cycle; STO/D hold afterwards.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            gnt      <= '0;
            STO      <= '0;
            D        <= '0;
            Enable   <= 1'b0;
            bad_addr <= 1'b0;
        end else begin
            gnt      <= '0;
            Enable   <= 1'b0;
            bad_addr <= 1'b0;
            if (start) begin
                gnt      <= winner;
                STO      <= win_addr;
                D        <= win_data;
                Enable   <= (win_addr != SEL_INVALID);
                bad_addr <= (win_addr == SEL_INVALID);
            end
        end
    end

    // State register.
    always_ff @(posedge Clock) begin
        if (Clear) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (req != '0) state_next = ST_WRITE;
`ifdef ALARM_SCAN_EN
            ST_WRITE: state_next = (Enable && (STO == SEL_TIME)) ? ST_SCAN : ST_IDLE;
            ST_SCAN:  if (scan_sel == SEL_LAST) state_next = ST_IDLE;
`else
            ST_WRITE: state_next = ST_IDLE;
`endif
            default:  state_next = ST_IDLE;
        endcase
    end

`ifdef ALARM_SCAN_EN
    logic [DATA_W-2:0] time_cap;
    logic [5:0]        shadow;
    logic [5:0]        hit_vec;
    logic              scan_done;

    // Compare the register currently on the read mux against the captured time.
    always_comb begin
        hit_vec = '0;
        if ((state == ST_SCAN) && scan_q[DATA_W-1] && (scan_q[DATA_W-2:0] == time_cap))
            hit_vec = 6'(1) << (scan_sel - SEL_FIRST);
    end

    assign scan_done = (state == ST_SCAN) && (scan_sel == SEL_LAST);

    // Scan sequencing: capture time on entry, step 1..6, publish mask on the last step.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            time_cap   <= '0;
            scan_sel   <= '0;
            shadow     <= '0;
            match_mask <= '0;
        end else if ((state == ST_WRITE) && (state_next == ST_SCAN)) begin
            time_cap <= D[DATA_W-2:0];
            scan_sel <= SEL_FIRST;
            shadow   <= '0;
        end else if (state == ST_SCAN) begin
            shadow <= shadow | hit_vec;
            if (scan_done) begin
                scan_sel   <= '0;
                match_mask <= shadow | hit_vec;
            end else begin
                scan_sel <= scan_sel + SEL_FIRST;
            end
        end
    end

    // Sticky alarm flag; a completing scan with a hit overrides a simultaneous ack.
    always_ff @(posedge Clock) begin
        if (Clear)                                      alarm_hit <= 1'b0;
        else if (scan_done && ((shadow | hit_vec) != '0)) alarm_hit <= 1'b1;
        else if (alarm_ack)                             alarm_hit <= 1'b0;
    end
`else
    logic unused_scan_inputs;
    assign unused_scan_inputs = ^{scan_q, alarm_ack};
    assign scan_sel   = '0;
    assign match_mask = '0;
    assign alarm_hit  = 1'b0;
`endif

endmodule

// File: tb/tb_reg_bank_controller.sv
// Self-checking bench for reg_bank_controller; holds a behavioural register
// bank and a round-robin / alarm reference model.
module tb_reg_bank_controller;

`ifdef ALARM_SCAN_EN
    localparam bit SCAN_ON = 1'b1;
`else
    localparam bit SCAN_ON = 1'b0;
`endif

    logic        Clock;
    logic        Clear;
    logic [2:0]  req;
    logic [2:0]  ra [3];
    logic [12:0] rd [3];
    logic [2:0]  gnt;
    logic [2:0]  STO;
    logic [12:0] D;
    logic        Enable;
    logic        bad_addr;
    logic [2:0]  scan_sel;
    logic [12:0] scan_q;
    logic [5:0]  match_mask;
    logic        alarm_hit;
    logic        alarm_ack;

    int          vectors = 0;
    int          miscompares = 0;
    logic [12:0] mdl [7];
    int          last;
    bit          exp_hit;
    logic [5:0]  exp_mask;
    logic [12:0] bank [8] = '{default: '0};

    reg_bank_controller #(.DATA_W(13), .SEL_W(3)) dut (
        .Clock      (Clock),
        .Clear      (Clear),
        .req        (req),
        .req_addr0  (ra[0]),
        .req_addr1  (ra[1]),
        .req_addr2  (ra[2]),
        .req_data0  (rd[0]),
        .req_data1  (rd[1]),
        .req_data2  (rd[2]),
        .gnt        (gnt),
        .STO        (STO),
        .D          (D),
        .Enable     (Enable),
        .bad_addr   (bad_addr),
        .scan_sel   (scan_sel),
        .scan_q     (scan_q),
        .match_mask (match_mask),
        .alarm_hit  (alarm_hit),
        .alarm_ack  (alarm_ack)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Physical register bank driven by the DUT write port.
    always @(posedge Clock) begin
        if (Enable && STO != 3'd7) bank[STO] <= D;
    end
    assign scan_q = bank[scan_sel];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    function automatic int rr_pick(input logic [2:0] m);
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (last + k) % 3;
            if (m[idx]) return idx;
        end
        return 0;
    endfunction

    function automatic logic [5:0] alarm_mask(input logic [11:0] t);
        logic [5:0] m;
        m = '0;
        for (int i = 1; i <= 6; i++)
            if (mdl[i][12] && mdl[i][11:0] == t) m[i-1] = 1'b1;
        return m;
    endfunction

    // Wait for the next grant and check it against the round-robin model.
    task automatic grant_step(output int lat, input bit drop);
        int w;
        w = rr_pick(req);
        lat = 0;
        do begin
            tick;
            lat++;
        end while (gnt == 3'b000 && lat < 40);
        check("gnt", gnt, 32'(1) << w);
        check("STO", STO, ra[w]);
        check("D", D, rd[w]);
        check("Enable", Enable, ra[w] != 3'd7);
        check("bad_addr", bad_addr, ra[w] == 3'd7);
        if (ra[w] != 3'd7) mdl[ra[w]] = rd[w];
        last = w;
        if (drop) req[w] = 1'b0;
    endtask

    // Single write from idle, including the scan that follows a time write.
    task automatic do_write(input int r, input logic [2:0] a, input logic [12:0] d);
        int lat;
        logic [5:0] m;
        ra[r] = a;
        rd[r] = d;
        req[r] = 1'b1;
        grant_step(lat, 1'b1);
        check("latency", lat, 1);
        if (a == 3'd0) begin
            m = alarm_mask(d[11:0]);
            if (alarm_ack) exp_hit = 1'b0;
            if (m != '0) exp_hit = 1'b1;
            for (int k = 1; k <= 6; k++) begin
                tick;
                check("scan_sel", scan_sel, SCAN_ON ? k : 0);
            end
            tick;
            exp_mask = SCAN_ON ? m : 6'd0;
            check("scan_sel_end", scan_sel, 0);
            check("match_mask", match_mask, exp_mask);
            check("alarm_hit", alarm_hit, SCAN_ON && exp_hit);
        end else begin
            tick;
            check("gnt_after", gnt, 0);
            check("Enable_after", Enable, 0);
            check("bad_addr_after", bad_addr, 0);
            check("STO_hold", STO, a);
            check("D_hold", D, d);
            check("scan_sel_idle", scan_sel, 0);
        end
    endtask

    task automatic pulse_clear;
        Clear = 1'b1;
        tick;
        Clear = 1'b0;
        last = 2;
        exp_hit = 1'b0;
        exp_mask = '0;
    endtask

    initial begin
        int t0, t1, lat, j;
        logic [12:0] d;
        Clear = 1'b1;
        req = '0;
        alarm_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ra[i] = '0;
            rd[i] = '0;
        end
        for (int i = 0; i < 7; i++) mdl[i] = '0;
        last = 2;
        exp_hit = 1'b0;
        exp_mask = '0;
        tick;
        tick;
        Clear = 1'b0;

        // Reset state
        check("rst_gnt", gnt, 0);
        check("rst_STO", STO, 0);
        check("rst_D", D, 0);
        check("rst_Enable", Enable, 0);
        check("rst_bad_addr", bad_addr, 0);
        check("rst_scan_sel", scan_sel, 0);
        check("rst_match_mask", match_mask, 0);
        check("rst_alarm_hit", alarm_hit, 0);

        // Two requesters: time write first, second grant after the full update
        ra[0] = 3'd0; rd[0] = 13'h0000;
        ra[1] = 3'd2; rd[1] = 13'h0123;
        req = 3'b011;
        t0 = -1;
        t1 = -1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick;
            if (gnt[0] && t0 < 0) begin
                t0 = cyc;
                check("t1_STO0", STO, 0);
                check("t1_Enable0", Enable, 1);
                req[0] = 1'b0;
                mdl[0] = rd[0];
            end
            if (gnt[1] && t1 < 0) begin
                t1 = cyc;
                check("t1_STO1", STO, 2);
                req[1] = 1'b0;
                mdl[2] = rd[1];
            end
        end
        check("t1_first_grant_cycle", t0, 1);
        check("t1_second_grant_cycle", t1, SCAN_ON ? 9 : 3);

        // Round-robin with all three held continuously
        pulse_clear;
        for (int i = 0; i < 3; i++) begin
            ra[i] = 3'(i + 1);
            rd[i] = 13'($urandom) & 13'h0FFF;
        end
        req = 3'b111;
        for (int g = 0; g < 4; g++) begin
            grant_step(lat, 1'b0);
            check("rr_latency", lat, (g == 0) ? 1 : 2);
        end
        req = '0;
        tick;

        // Armed alarm at reg 3 matches, unarmed reg 5 does not
        do_write(2, 3'd3, 13'h10A5);
        do_write(2, 3'd5, 13'h00A5);
        do_write(0, 3'd0, 13'h00A5);
        check("alarm_mask_reg3", match_mask, SCAN_ON ? 6'b000100 : 6'b0);
        alarm_ack = 1'b1;
        tick;
        alarm_ack = 1'b0;
        exp_hit = 1'b0;
        check("ack_clears_hit", alarm_hit, 0);
        check("ack_keeps_mask", match_mask, exp_mask);

        // Hit and ack on the same edge: hit wins
        alarm_ack = 1'b1;
        do_write(0, 3'd0, 13'h00A5);
        alarm_ack = 1'b0;
        alarm_ack = 1'b1;
        tick;
        alarm_ack = 1'b0;
        exp_hit = 1'b0;
        check("ack_after_coincide", alarm_hit, 0);

        // Invalid address: grant pulses, no write, no scan
        do_write(1, 3'd7, 13'h1ABC);

        // Clear on the third scan cycle discards the scan
        ra[0] = 3'd0;
        rd[0] = 13'h00A5;
        req[0] = 1'b1;
        grant_step(lat, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            tick;
            check("pre_clear_scan_sel", scan_sel, SCAN_ON ? k : 0);
        end
        pulse_clear;
        check("clr_gnt", gnt, 0);
        check("clr_STO", STO, 0);
        check("clr_D", D, 0);
        check("clr_Enable", Enable, 0);
        check("clr_bad_addr", bad_addr, 0);
        check("clr_scan_sel", scan_sel, 0);
        check("clr_match_mask", match_mask, 0);
        check("clr_alarm_hit", alarm_hit, 0);
        do_write(1, 3'd4, 13'h0042);

        // Random contention on alarm registers and the invalid address
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < 3; r++) begin
                if (!req[r] && $urandom_range(0, 1) == 1) begin
                    ra[r] = 3'($urandom_range(1, 7));
                    rd[r] = 13'($urandom);
                    req[r] = 1'b1;
                end
            end
            if (req == '0) begin
                j = $urandom_range(0, 2);
                ra[j] = 3'($urandom_range(1, 6));
                rd[j] = 13'($urandom);
                req[j] = 1'b1;
            end
            grant_step(lat, 1'b1);
        end
        for (int n = 0; n < 3 && req != '0; n++) grant_step(lat, 1'b1);
        tick;

        // Random time writes scanned against the model bank
        for (int it = 0; it < 8; it++) begin
            j = $urandom_range(1, 6);
            d = {1'b0, mdl[j][11:0]};
            if ($urandom_range(0, 3) == 0) d = 13'($urandom) & 13'h0FFF;
            do_write(0, 3'd0, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
